// File: rtl/alu_op_issue_pkg.sv
// rtl/alu_op_issue_pkg.sv - shared ALU op codes, RV32 field constants and issue FSM states
package alu_op_issue_pkg;

  // ALU control codes consumed by the EX stage
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  // RV32 major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MULW = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_op_issue_decode.sv
// rtl/alu_op_issue_decode.sv - combinational RV32 instruction to ALU control decode
module alu_op_decode
  import alu_op_issue_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [2:0]  alu_ctrl_o,
  output logic        alu_src_o,
  output logic [31:0] imm_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  logic [6:0]  w_opc;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;

  assign w_opc   = inst_i[6:0];
  assign w_f3    = inst_i[14:12];
  assign w_f7    = inst_i[31:25];
  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};

  // Unmatched encodings fall back to a side-effect-free ADD (no write, rs2 operand)
  always_comb begin
    alu_ctrl_o  = ALU_ADD;
    alu_src_o   = 1'b0;
    imm_o       = '0;
    reg_write_o = 1'b0;
    illegal_o   = 1'b1;
    case (w_opc)
      OPC_OP: begin
        illegal_o   = 1'b0;
        reg_write_o = 1'b1;
        if (w_f7 == F7_BASE && w_f3 == F3_AND)        alu_ctrl_o = ALU_AND;
        else if (w_f7 == F7_BASE && w_f3 == F3_XOR)   alu_ctrl_o = ALU_XOR;
        else if (w_f7 == F7_BASE && w_f3 == F3_SLL)   alu_ctrl_o = ALU_SLL;
        else if (w_f7 == F7_BASE && w_f3 == F3_ADD)   alu_ctrl_o = ALU_ADD;
        else if (w_f7 == F7_ALT && w_f3 == F3_ADD)    alu_ctrl_o = ALU_SUB;
        else if (w_f7 == F7_MULDIV && w_f3 == F3_ADD) alu_ctrl_o = ALU_MUL;
        else begin
          illegal_o   = 1'b1;
          reg_write_o = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (w_f3 == F3_ADD) begin
          alu_ctrl_o  = ALU_ADDI;
          alu_src_o   = 1'b1;
          imm_o       = w_imm_i;
          reg_write_o = 1'b1;
          illegal_o   = 1'b0;
        end else if (w_f3 == F3_SR && w_f7 == F7_ALT) begin
          alu_ctrl_o  = ALU_SRAI;
          alu_src_o   = 1'b1;
          imm_o       = {27'd0, inst_i[24:20]};
          reg_write_o = 1'b1;
          illegal_o   = 1'b0;
        end
      end
      OPC_LOAD: begin
        alu_src_o   = 1'b1;
        imm_o       = w_imm_i;
        reg_write_o = 1'b1;
        illegal_o   = 1'b0;
      end
      OPC_STORE: begin
        alu_src_o   = 1'b1;
        imm_o       = w_imm_s;
        illegal_o   = 1'b0;
      end
      OPC_BRANCH: begin
        alu_ctrl_o  = ALU_SUB;
        illegal_o   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ID/EX issue register with MUL occupancy bubbles (optional ALU_OP_ISSUE_PERF_EN counters)
module alu_op_issue
  import alu_op_issue_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic        flush_i,
  output logic [2:0]  ALUCtrl_o,
  output logic        alu_src_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        illegal_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef ALU_OP_ISSUE_PERF_EN
  ,
  output logic [31:0] issued_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  issue_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [2:0]       r_alu_ctrl;
  logic             r_alu_src;
  logic [31:0]      r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic             r_illegal;

  logic [2:0]       w_dec_ctrl;
  logic             w_dec_src;
  logic [31:0]      w_dec_imm;
  logic             w_dec_rw;
  logic             w_dec_ill;
  logic             w_mul_stall;
  logic             w_load;

  alu_op_decode u_decode (
    .inst_i      (inst_i),
    .alu_ctrl_o  (w_dec_ctrl),
    .alu_src_o   (w_dec_src),
    .imm_o       (w_dec_imm),
    .reg_write_o (w_dec_rw),
    .illegal_o   (w_dec_ill)
  );

  // A held MUL leaving to EX must not be followed by a refill in the same edge
  assign w_mul_stall = (r_alu_ctrl == ALU_MUL) && (MUL_LAT > 1);

  // Upstream may push whenever the register is empty or is being drained this cycle
  always_comb begin
    inst_ready_o = 1'b0;
    case (r_state)
      ST_IDLE: inst_ready_o = 1'b1;
      ST_HOLD: inst_ready_o = ready_i && !w_mul_stall;
      default: inst_ready_o = 1'b0;
    endcase
  end

  assign w_load = inst_valid_i && inst_ready_o && !flush_i;

  // Issue FSM: entry occupancy, MUL bubble countdown, flush recovery
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (ready_i) begin
            if (w_mul_stall) begin
              r_state <= ST_MULW;
              r_valid <= 1'b0;
              r_cnt   <= CNT_INIT;
            end else if (!w_load) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        ST_MULW: begin
          if (r_cnt <= CNT_ONE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output payload captured on accept; illegal flags only the first cycle of the entry
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_alu_ctrl  <= ALU_ADD;
      r_alu_src   <= 1'b0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_load && w_dec_ill;
      if (w_load) begin
        r_alu_ctrl  <= w_dec_ctrl;
        r_alu_src   <= w_dec_src;
        r_imm       <= w_dec_imm;
        r_rs1       <= inst_i[19:15];
        r_rs2       <= inst_i[24:20];
        r_rd        <= inst_i[11:7];
        r_reg_write <= w_dec_rw;
      end
    end
  end

  assign valid_o     = r_valid;
  assign ALUCtrl_o   = r_alu_ctrl;
  assign alu_src_o   = r_alu_src;
  assign imm_o       = r_imm;
  assign rs1_o       = r_rs1;
  assign rs2_o       = r_rs2;
  assign rd_o        = r_rd;
  assign reg_write_o = r_reg_write;
  assign illegal_o   = r_illegal;

`ifdef ALU_OP_ISSUE_PERF_EN
  logic [31:0] r_issued_cnt;
  logic [31:0] r_bubble_cnt;

  // Free-running event counters; flush deliberately leaves them alone
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_issued_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_valid && ready_i) r_issued_cnt <= r_issued_cnt + 32'd1;
      if (r_state == ST_MULW) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign issued_cnt_o = r_issued_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
